// File: rtl/coin_pulse_gen_if.sv
// rtl/coin_pulse_gen_if.sv - coin sensor inputs and pulse/status outputs of the coin front end
interface coin_pulse_gen_if;
  logic       coin_d_raw;
  logic       coin_q_raw;
  logic       accept_en;
  logic       D_in;
  logic       Q_in;
  logic       busy;
  logic       ovf_err;
  logic [7:0] d_count;
  logic [7:0] q_count;

  modport master (
    output coin_d_raw, coin_q_raw, accept_en,
    input  D_in, Q_in, busy, ovf_err, d_count, q_count
  );

  modport slave (
    input  coin_d_raw, coin_q_raw, accept_en,
    output D_in, Q_in, busy, ovf_err, d_count, q_count
  );
endinterface

// File: rtl/coin_pulse_gen.sv
// rtl/coin_pulse_gen.sv - synchronise, debounce and arbitrate coin sensors into single-cycle pulses
module coin_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int GAP_CYCLES      = 2
) (
  input logic             clock,
  input logic             rstn,
  coin_pulse_gen_if.slave bus
);

  localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

  // Channel 0 is the dollar sensor, channel 1 the quarter sensor.
  logic [1:0] raw;
  logic [1:0] s1, s2, deb, rise;
  logic [3:0] cnt [2];

  logic       pend_d, pend_q, ovf_q;
  logic [7:0] d_cnt, q_cnt;
  logic       d_pulse, q_pulse;
  logic [3:0] gap_cnt;
  state_t     state;

  state_t     state_n;
  logic       d_pulse_n, q_pulse_n;
  logic [3:0] gap_n;
  logic       clr_d, clr_q;

  assign raw = {bus.coin_q_raw, bus.coin_d_raw};

  always_ff @(posedge clock) begin
    if (!rstn) begin
      s1  <= '0;
      s2  <= '0;
      deb <= '0;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DEB_LAST) begin
          deb[i] <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 4'd1;
        end
      end
    end
  end

  // An event is the edge on which deb is about to go 0 -> 1.
  always_comb begin
    rise = '0;
    for (int i = 0; i < 2; i++) begin
      rise[i] = s2[i] & ~deb[i] & (cnt[i] == DEB_LAST);
    end
  end

  always_comb begin
    state_n   = state;
    d_pulse_n = 1'b0;
    q_pulse_n = 1'b0;
    gap_n     = gap_cnt;
    clr_d     = 1'b0;
    clr_q     = 1'b0;
    case (state)
      IDLE: begin
        if (pend_d) begin
          d_pulse_n = 1'b1;
          clr_d     = 1'b1;
          state_n   = PULSE;
        end else if (pend_q) begin
          q_pulse_n = 1'b1;
          clr_q     = 1'b1;
          state_n   = PULSE;
        end
      end
      PULSE: begin
        gap_n   = GAP_LAST;
        state_n = GAP;
      end
      GAP: begin
        if (gap_cnt == 4'd0) state_n = IDLE;
        else                 gap_n   = gap_cnt - 4'd1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rstn) begin
      state   <= IDLE;
      d_pulse <= 1'b0;
      q_pulse <= 1'b0;
      gap_cnt <= '0;
    end else begin
      state   <= state_n;
      d_pulse <= d_pulse_n;
      q_pulse <= q_pulse_n;
      gap_cnt <= gap_n;
    end
  end

  // A new event on the clearing edge wins, so the coin is kept rather than lost.
  always_ff @(posedge clock) begin
    if (!rstn) begin
      pend_d <= 1'b0;
      pend_q <= 1'b0;
      ovf_q  <= 1'b0;
      d_cnt  <= '0;
      q_cnt  <= '0;
    end else begin
      if (rise[0] && bus.accept_en) pend_d <= 1'b1;
      else if (clr_d)               pend_d <= 1'b0;
      if (rise[1] && bus.accept_en) pend_q <= 1'b1;
      else if (clr_q)               pend_q <= 1'b0;
      if (bus.accept_en && ((rise[0] && pend_d && !clr_d) || (rise[1] && pend_q && !clr_q)))
        ovf_q <= 1'b1;
      if (d_pulse_n && d_cnt != 8'hFF) d_cnt <= d_cnt + 8'd1;
      if (q_pulse_n && q_cnt != 8'hFF) q_cnt <= q_cnt + 8'd1;
    end
  end

  assign bus.D_in    = d_pulse;
  assign bus.Q_in    = q_pulse;
  assign bus.busy    = (state != IDLE) | pend_d | pend_q;
  assign bus.ovf_err = ovf_q;
  assign bus.d_count = d_cnt;
  assign bus.q_count = q_cnt;

endmodule

// File: tb/tb_coin_pulse_gen.sv
// tb/tb_coin_pulse_gen.sv - directed self-checking bench for coin_pulse_gen
module tb_coin_pulse_gen;
  logic clock;
  logic rstn;

  coin_pulse_gen_if if_a ();
  coin_pulse_gen_if if_b ();

  coin_pulse_gen u_dut (.clock(clock), .rstn(rstn), .bus(if_a));
  coin_pulse_gen #(.DEBOUNCE_CYCLES(4), .GAP_CYCLES(15)) u_ovf (.clock(clock), .rstn(rstn), .bus(if_b));

  int n_cmp = 0;
  int n_err = 0;
  int np_d = 0;
  int np_q = 0;
  int nb_d = 0;
  logic viol = 1'b0;
  logic prev_hi = 1'b0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and sample just after it.
  task automatic step();
    @(posedge clock);
    #1;
    if (if_a.D_in === 1'b1) np_d++;
    if (if_a.Q_in === 1'b1) np_q++;
    if (if_b.D_in === 1'b1) nb_d++;
    if ((if_a.D_in & if_a.Q_in) || ((if_a.D_in | if_a.Q_in) & prev_hi)) viol = 1'b1;
    prev_hi = if_a.D_in | if_a.Q_in;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // ch: 0 = dut dollar, 1 = dut quarter, 2 = overflow-dut dollar
  task automatic coin(input int ch, input int hi, input int lo);
    case (ch)
      0: if_a.coin_d_raw = 1'b1;
      1: if_a.coin_q_raw = 1'b1;
      default: if_b.coin_d_raw = 1'b1;
    endcase
    run(hi);
    case (ch)
      0: if_a.coin_d_raw = 1'b0;
      1: if_a.coin_q_raw = 1'b0;
      default: if_b.coin_d_raw = 1'b0;
    endcase
    run(lo);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    run(2);
    rstn = 1'b1;
    np_d = 0; np_q = 0; nb_d = 0;
  endtask

  initial begin
    rstn = 1'b0;
    if_a.coin_d_raw = 1'b0; if_a.coin_q_raw = 1'b0; if_a.accept_en = 1'b1;
    if_b.coin_d_raw = 1'b0; if_b.coin_q_raw = 1'b0; if_b.accept_en = 1'b1;
    run(2);
    check("rst_D_in", if_a.D_in, 0);
    check("rst_Q_in", if_a.Q_in, 0);
    check("rst_busy", if_a.busy, 0);
    check("rst_ovf", if_a.ovf_err, 0);
    check("rst_d_count", if_a.d_count, 0);
    check("rst_q_count", if_a.q_count, 0);
    rstn = 1'b1;

    // Single quarter: pulse high between edges 6 and 7.
    np_d = 0; np_q = 0;
    if_a.coin_q_raw = 1'b1;
    run(6);
    check("q_edge5_low", if_a.Q_in, 0);
    check("q_edge5_busy", if_a.busy, 1);
    step();
    check("q_edge6_high", if_a.Q_in, 1);
    step();
    check("q_edge7_low", if_a.Q_in, 0);
    check("q_count_1", if_a.q_count, 1);
    run(2);
    if_a.coin_q_raw = 1'b0;
    run(12);
    check("q_single_pulses", np_q, 1);
    check("q_no_dollar", np_d, 0);

    // Bounce rejection.
    np_d = 0;
    coin(0, 2, 2);
    coin(0, 2, 2);
    coin(0, 8, 15);
    check("bounce_pulses", np_d, 1);
    check("bounce_d_count", if_a.d_count, 1);

    // Simultaneous dollar and quarter.
    do_reset();
    if_a.coin_d_raw = 1'b1;
    if_a.coin_q_raw = 1'b1;
    run(7);
    check("sim_D_edge6", if_a.D_in, 1);
    check("sim_Q_edge6", if_a.Q_in, 0);
    run(3);
    check("sim_Q_edge9", if_a.Q_in, 0);
    step();
    check("sim_Q_edge10", if_a.Q_in, 1);
    check("sim_D_edge10", if_a.D_in, 0);
    run(4);
    check("sim_busy_low", if_a.busy, 0);
    if_a.coin_d_raw = 1'b0;
    if_a.coin_q_raw = 1'b0;
    run(10);
    check("sim_d_pulses", np_d, 1);
    check("sim_q_pulses", np_q, 1);

    // Disabled acceptance, then enabled.
    np_q = 0;
    if_a.accept_en = 1'b0;
    coin(1, 6, 6);
    run(4);
    if_a.accept_en = 1'b1;
    check("dis_q_pulses", np_q, 0);
    check("dis_q_count", if_a.q_count, 1);
    check("dis_ovf", if_a.ovf_err, 0);
    coin(1, 6, 8);
    check("en_q_pulses", np_q, 1);
    check("en_q_count", if_a.q_count, 2);

    // Overflow on the long-gap instance.
    nb_d = 0;
    coin(2, 4, 4);
    coin(2, 4, 4);
    coin(2, 4, 4);
    run(60);
    check("ovf_pulses", nb_d, 2);
    check("ovf_d_count", if_b.d_count, 2);
    check("ovf_flag", if_b.ovf_err, 1);
    run(20);
    check("ovf_sticky", if_b.ovf_err, 1);
    check("ovf_other_clear", if_a.ovf_err, 0);

    // Raw line held high through reset yields one event.
    if_a.coin_q_raw = 1'b1;
    do_reset();
    run(12);
    if_a.coin_q_raw = 1'b0;
    run(10);
    check("held_rst_pulses", np_q, 1);
    check("held_rst_q_count", if_a.q_count, 1);
    check("held_rst_ovf_b", if_b.ovf_err, 0);

    // Saturation.
    for (int k = 0; k < 260; k++) coin(1, 5, 5);
    run(10);
    check("sat_q_count", if_a.q_count, 255);

    // Reset mid-pulse.
    if_a.coin_d_raw = 1'b1;
    run(7);
    check("mid_D_high", if_a.D_in, 1);
    rstn = 1'b0;
    if_a.coin_d_raw = 1'b0;
    step();
    check("mid_rst_D_in", if_a.D_in, 0);
    check("mid_rst_Q_in", if_a.Q_in, 0);
    check("mid_rst_busy", if_a.busy, 0);
    check("mid_rst_d_count", if_a.d_count, 0);
    check("mid_rst_q_count", if_a.q_count, 0);
    check("mid_rst_ovf", if_a.ovf_err, 0);
    rstn = 1'b1;
    np_d = 0; np_q = 0;
    run(12);
    check("mid_rst_no_pulse", np_d + np_q, 0);
    check("pulse_spacing", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
